// File: rtl/mem_stage_access_pkg.sv
// Shared types and constants for the memory-stage access controller.
// Default datapath widths, boolean constants and the access FSM state encoding.
package mem_stage_access_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 32;
    localparam int REG_W_DEF  = 5;

    typedef logic [DATA_W_DEF-1:0] DataPath;
    typedef logic [PC_W_DEF-1:0]   InsnAddrPath;
    typedef logic [REG_W_DEF-1:0]  RegNumPath;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } MemState;

    function automatic logic isWordAligned(input logic [1:0] lowBits);
        return lowBits == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_access_memwb.sv
// MEM/WB pipeline register with load-enable and bubble insertion.
// A held (stalled) register still clears its control bits so writeback sees a bubble.
module memwb_reg
    import mem_stage_access_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic              rdLoad,
    input  logic              regWrite,
    input  logic              memToReg,
    input  logic [DATA_W-1:0] rdData,
    input  logic [DATA_W-1:0] aluOut,
    input  logic [REG_W-1:0]  rfWrNum,
    output logic              wbRegWrite,
    output logic              wbMemToReg,
    output logic [DATA_W-1:0] wbRdData,
    output logic [DATA_W-1:0] wbAluOut,
    output logic [REG_W-1:0]  wbRfWrNum
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wbRegWrite <= FALSE;
            wbMemToReg <= FALSE;
            wbRdData   <= '0;
            wbAluOut   <= '0;
            wbRfWrNum  <= '0;
        end else if (load) begin
            wbRegWrite <= regWrite & ~bubble;
            wbMemToReg <= memToReg & ~bubble;
            wbAluOut   <= aluOut;
            wbRfWrNum  <= rfWrNum;
            if (rdLoad) begin
                wbRdData <= rdData;
            end
        end else begin
            wbRegWrite <= FALSE;
            wbMemToReg <= FALSE;
        end
    end

endmodule

// File: rtl/mem_stage_access.sv
// Memory-stage access controller: EX/MEM consumer, branch resolve, data-memory
// req/ack sequencing with timeout abort, and MEM/WB register drive.
//
//   state | meaning
//   IDLE  | no access outstanding; zero-wait accesses complete here
//   WAIT  | request outstanding, counting cycles until ack or timeout
//   ABORT | one-cycle drop of the request; instruction retires as a bubble
module mem_stage_access
    import mem_stage_access_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inMemToReg,
    input  logic              inRegWrite,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic              inBranch,
    input  logic [PC_W-1:0]   inPcOut,
    input  logic              inIsEqual,
    input  logic [DATA_W-1:0] inAluOut,
    input  logic [DATA_W-1:0] inStoreData,
    input  logic [REG_W-1:0]  inRfWrNum,
    output logic              dmReq,
    output logic              dmWe,
    output logic [DATA_W-1:0] dmAddr,
    output logic [DATA_W-1:0] dmWrData,
    input  logic              dmAck,
    input  logic [DATA_W-1:0] dmRdData,
    output logic              stall,
    output logic              pcSrc,
    output logic [PC_W-1:0]   branchTarget,
    output logic              wbRegWrite,
    output logic              wbMemToReg,
    output logic [DATA_W-1:0] wbRdData,
    output logic [DATA_W-1:0] wbAluOut,
    output logic [REG_W-1:0]  wbRfWrNum,
    output logic              errAlign,
    output logic              errTimeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    MemState          state;
    MemState          stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [CNT_W-1:0] cntInc;
    logic             setTimeout;
    logic             memOp;
    logic             misaligned;
    logic             retireBubble;
    logic             rdLoad;

    assign memOp        = inMemRead | inMemWrite;
    assign misaligned   = memOp & ~isWordAligned(inAluOut[1:0]);
    assign dmReq        = memOp & ~misaligned & (state != ABORT);
    assign dmWe         = inMemWrite & ~inMemRead;
    assign dmAddr       = inAluOut;
    assign dmWrData     = inStoreData;
    assign stall        = dmReq & ~dmAck;
    assign pcSrc        = inBranch & inIsEqual;
    assign branchTarget = inPcOut;
    assign retireBubble = misaligned | (state == ABORT);
    assign rdLoad       = dmReq & dmAck & inMemRead;
    assign cntInc       = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            errAlign   <= FALSE;
            errTimeout <= FALSE;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (misaligned) begin
                errAlign <= TRUE;
            end
            if (setTimeout) begin
                errTimeout <= TRUE;
            end
        end
    end

    // The IDLE cycle of a stalled access counts toward TIMEOUT, so the
    // request is held for exactly TIMEOUT cycles before the abort.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        setTimeout = FALSE;
        case (state)
            IDLE: begin
                if (dmReq && !dmAck) begin
                    cntNext = '0;
                    if (TIMEOUT == 1) begin
                        stateNext  = ABORT;
                        setTimeout = TRUE;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!dmReq || dmAck) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cntInc;
                    if (cntInc == CNT_LAST) begin
                        stateNext  = ABORT;
                        setTimeout = TRUE;
                    end
                end
            end
            ABORT: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    memwb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) uMemWb (
        .clk        (clk),
        .rst        (rst),
        .load       (~stall),
        .bubble     (retireBubble),
        .rdLoad     (rdLoad),
        .regWrite   (inRegWrite),
        .memToReg   (inMemToReg),
        .rdData     (dmRdData),
        .aluOut     (inAluOut),
        .rfWrNum    (inRfWrNum),
        .wbRegWrite (wbRegWrite),
        .wbMemToReg (wbMemToReg),
        .wbRdData   (wbRdData),
        .wbAluOut   (wbAluOut),
        .wbRfWrNum  (wbRfWrNum)
    );

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access with TIMEOUT=4 and hand-computed expectations.
module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        inMemToReg, inRegWrite, inMemRead, inMemWrite, inBranch;
    logic [31:0] inPcOut;
    logic        inIsEqual;
    logic [31:0] inAluOut, inStoreData;
    logic [4:0]  inRfWrNum;
    logic        dmReq, dmWe, dmAck, stall, pcSrc;
    logic [31:0] dmAddr, dmWrData, dmRdData, branchTarget;
    logic        wbRegWrite, wbMemToReg, errAlign, errTimeout;
    logic [31:0] wbRdData, wbAluOut;
    logic [4:0]  wbRfWrNum;

    int checks = 0;
    int errors = 0;
    int stallCycles;

    mem_stage_access #(.DATA_W(32), .PC_W(32), .REG_W(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .inMemToReg(inMemToReg), .inRegWrite(inRegWrite), .inMemRead(inMemRead),
        .inMemWrite(inMemWrite), .inBranch(inBranch), .inPcOut(inPcOut),
        .inIsEqual(inIsEqual), .inAluOut(inAluOut), .inStoreData(inStoreData),
        .inRfWrNum(inRfWrNum), .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr),
        .dmWrData(dmWrData), .dmAck(dmAck), .dmRdData(dmRdData), .stall(stall),
        .pcSrc(pcSrc), .branchTarget(branchTarget), .wbRegWrite(wbRegWrite),
        .wbMemToReg(wbMemToReg), .wbRdData(wbRdData), .wbAluOut(wbAluOut),
        .wbRfWrNum(wbRfWrNum), .errAlign(errAlign), .errTimeout(errTimeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setOp(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [4:0] rf, input logic [31:0] alu, input logic [31:0] sd);
        inMemRead   = rd;
        inMemWrite  = wr;
        inRegWrite  = rw;
        inMemToReg  = m2r;
        inRfWrNum   = rf;
        inAluOut    = alu;
        inStoreData = sd;
    endtask

    initial begin
        rst = 1'b1;
        inBranch = 1'b0; inIsEqual = 1'b0; inPcOut = 32'h0;
        dmAck = 1'b0; dmRdData = 32'h0;
        setOp(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_wbRegWrite", {31'b0, wbRegWrite}, 32'd0);
        check("rst_wbAluOut", wbAluOut, 32'h0);
        check("rst_wbRdData", wbRdData, 32'h0);
        check("rst_errs", {30'b0, errAlign, errTimeout}, 32'd0);
        check("rst_req_stall", {30'b0, dmReq, stall}, 32'd0);

        // ALU op, no memory access
        setOp(0, 0, 1, 0, 5'd7, 32'h1234, 32'h0);
        #1;
        check("alu_stall", {31'b0, stall}, 32'd0);
        check("alu_dmReq", {31'b0, dmReq}, 32'd0);
        tick();
        check("alu_wbRegWrite", {31'b0, wbRegWrite}, 32'd1);
        check("alu_wbRfWrNum", {27'b0, wbRfWrNum}, 32'd7);
        check("alu_wbAluOut", wbAluOut, 32'h1234);

        // Load at 0x40 acked after three stall cycles
        setOp(1, 0, 1, 1, 5'd3, 32'h40, 32'h0);
        #1;
        check("ld_dmReq", {31'b0, dmReq}, 32'd1);
        check("ld_dmAddr", dmAddr, 32'h40);
        check("ld_dmWe", {31'b0, dmWe}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("ld_stall_hi", {31'b0, stall}, 32'd1);
            tick();
            check("ld_bubble", {31'b0, wbRegWrite}, 32'd0);
        end
        dmAck = 1'b1;
        dmRdData = 32'hDEADBEEF;
        #1;
        check("ld_ack_stall", {31'b0, stall}, 32'd0);
        tick();
        dmAck = 1'b0;
        check("ld_wbRdData", wbRdData, 32'hDEADBEEF);
        check("ld_wbMemToReg", {31'b0, wbMemToReg}, 32'd1);
        check("ld_wbRegWrite", {31'b0, wbRegWrite}, 32'd1);
        check("ld_wbRfWrNum", {27'b0, wbRfWrNum}, 32'd3);

        // Store at 0x80, zero-wait
        setOp(0, 1, 0, 0, 5'd0, 32'h80, 32'hCAFE);
        dmAck = 1'b1;
        dmRdData = 32'h11111111;
        #1;
        check("st_dmWe", {31'b0, dmWe}, 32'd1);
        check("st_dmWrData", dmWrData, 32'hCAFE);
        check("st_dmReq", {31'b0, dmReq}, 32'd1);
        check("st_stall", {31'b0, stall}, 32'd0);
        tick();
        check("st_wbRegWrite", {31'b0, wbRegWrite}, 32'd0);
        check("st_rd_hold", wbRdData, 32'hDEADBEEF);

        // Ack without a request is ignored
        setOp(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        dmRdData = 32'h55555555;
        tick();
        dmAck = 1'b0;
        check("noreq_ack_rd_hold", wbRdData, 32'hDEADBEEF);

        // Misaligned load at 0x42
        setOp(1, 0, 1, 1, 5'd4, 32'h42, 32'h0);
        #1;
        check("mis_dmReq", {31'b0, dmReq}, 32'd0);
        check("mis_stall", {31'b0, stall}, 32'd0);
        tick();
        check("mis_errAlign", {31'b0, errAlign}, 32'd1);
        check("mis_bubble", {31'b0, wbRegWrite}, 32'd0);
        setOp(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        check("mis_sticky", {31'b0, errAlign}, 32'd1);

        // Load never acked: TIMEOUT=4 stall cycles then one ABORT cycle
        setOp(1, 0, 1, 1, 5'd5, 32'h44, 32'h0);
        #1;
        stallCycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (!stall) break;
            stallCycles++;
            tick();
        end
        check("to_stall_cycles", stallCycles, 32'd4);
        check("to_abort_dmReq", {31'b0, dmReq}, 32'd0);
        check("to_abort_stall", {31'b0, stall}, 32'd0);
        check("to_errTimeout", {31'b0, errTimeout}, 32'd1);
        tick();
        setOp(0, 1'b0, 1, 0, 5'd9, 32'h2222, 32'h0);
        check("to_bubble", {31'b0, wbRegWrite}, 32'd0);
        #1;
        check("to_resume_stall", {31'b0, stall}, 32'd0);
        tick();
        check("to_resume_wbRegWrite", {31'b0, wbRegWrite}, 32'd1);
        check("to_resume_wbAluOut", wbAluOut, 32'h2222);
        check("to_sticky", {31'b0, errTimeout}, 32'd1);

        // Branch resolution
        setOp(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        inBranch = 1'b1; inIsEqual = 1'b1; inPcOut = 32'h100;
        #1;
        check("br_pcSrc", {31'b0, pcSrc}, 32'd1);
        check("br_target", branchTarget, 32'h100);
        inIsEqual = 1'b0;
        #1;
        check("br_not_taken", {31'b0, pcSrc}, 32'd0);
        inBranch = 1'b0;

        // Reset while waiting on a load
        setOp(1, 0, 1, 1, 5'd6, 32'h48, 32'h0);
        tick();
        check("rstw_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setOp(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("rstw_wb_ctrl", {30'b0, wbRegWrite, wbMemToReg}, 32'd0);
        check("rstw_wbRdData", wbRdData, 32'h0);
        check("rstw_wbAluOut", wbAluOut, 32'h0);
        check("rstw_wbRfWrNum", {27'b0, wbRfWrNum}, 32'd0);
        check("rstw_errs", {30'b0, errAlign, errTimeout}, 32'd0);

        // Fresh load after reset should again hold for the full four cycles
        setOp(1, 0, 1, 1, 5'd2, 32'h4C, 32'h0);
        #1;
        stallCycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (!stall) break;
            stallCycles++;
            tick();
        end
        check("rstw_idle_stall_cycles", stallCycles, 32'd4);
        tick();
        setOp(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
